// File: rtl/vga_sync_decoder.sv
// Recovers column/row from incoming VGA syncs, verifies the timing of every line and
// frame, and only marks pixels valid once a complete frame has checked clean.
module vga_sync_decoder #(
  parameter int H_PIXELS = 640,
  parameter int H_FP     = 16,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 48,
  parameter int V_PIXELS = 480,
  parameter int V_FP     = 10,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [9:0] column,
  output logic [8:0] row,
  output logic [7:0] pix_r,
  output logic [7:0] pix_g,
  output logic [7:0] pix_b,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_error
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  typedef struct packed { logic [7:0] r; logic [7:0] g; logic [7:0] b; } rgb_t;

  localparam logic [9:0] H_TOTAL = 10'(H_PIXELS + H_FP + H_PULSE + H_BP);
  localparam logic [9:0] V_TOTAL = 10'(V_PIXELS + V_FP + V_PULSE + V_BP);
  localparam logic [9:0] H_PW    = 10'(H_PULSE);
  localparam logic [9:0] V_PW    = 10'(V_PULSE);
  localparam logic [9:0] H_START = 10'(H_PULSE + H_BP);
  localparam logic [9:0] H_END   = 10'(H_PULSE + H_BP + H_PIXELS - 1);
  localparam logic [9:0] V_START = 10'(V_PULSE + V_BP);
  localparam logic [9:0] V_END   = 10'(V_PULSE + V_BP + V_PIXELS - 1);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  logic       hs_q, hs_p, vs_q, vs_p;
  rgb_t       rgb_q;
  logic [9:0] hcount, vcount, h_inc, v_line, hcnt_cur, vcnt_cur;
  logic       h_rise, h_fall, v_rise, v_fall, viol;
  logic       in_win, lock_nxt, err_nxt, valid_nxt;
  state_t     state, state_nxt;

  // Syncs reset inactive so a sync already asserted after reset reads as an edge.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hs_q  <= ~SYNC_POL;
      hs_p  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      vs_p  <= ~SYNC_POL;
      rgb_q <= '0;
    end else begin
      hs_q  <= h_sync;
      hs_p  <= hs_q;
      vs_q  <= v_sync;
      vs_p  <= vs_q;
      rgb_q <= '{r: red, g: green, b: blue};
    end
  end

  assign h_rise = (hs_q == SYNC_POL) && (hs_p != SYNC_POL);
  assign h_fall = (hs_q != SYNC_POL) && (hs_p == SYNC_POL);
  assign v_rise = (vs_q == SYNC_POL) && (vs_p != SYNC_POL);
  assign v_fall = (vs_q != SYNC_POL) && (vs_p == SYNC_POL);

  // h_inc / v_line are what the counters would hold without a reload, which is
  // exactly the interval measured at each edge.
  always_comb begin
    h_inc  = (hcount == CNT_MAX) ? CNT_MAX : hcount + 10'd1;
    v_line = vcount;
    if (h_rise && vcount != CNT_MAX) v_line = vcount + 10'd1;
    hcnt_cur = h_rise ? '0 : h_inc;
    vcnt_cur = v_rise ? '0 : v_line;
    viol = (h_rise && h_inc  != H_TOTAL) ||
           (h_fall && h_inc  != H_PW)    ||
           (v_rise && v_line != V_TOTAL) ||
           (v_fall && v_line != V_PW)    ||
           (!h_rise && hcount == CNT_MAX - 10'd1);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= hcnt_cur;
      vcount <= vcnt_cur;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (v_rise) state_nxt = MEASURE;
      MEASURE: if (viol) state_nxt = SEARCH;
               else if (v_rise) state_nxt = LOCKED;
      LOCKED:  if (viol) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    err_nxt   = (state != SEARCH) && viol;
    lock_nxt  = (state_nxt == LOCKED);
    in_win    = (hcnt_cur >= H_START) && (hcnt_cur <= H_END) &&
                (vcnt_cur >= V_START) && (vcnt_cur <= V_END);
    valid_nxt = lock_nxt && in_win;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      column       <= '0;
      row          <= '0;
      pix_r        <= '0;
      pix_g        <= '0;
      pix_b        <= '0;
      pixel_valid  <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      pixel_valid  <= valid_nxt;
      frame_start  <= valid_nxt && (hcnt_cur == H_START) && (vcnt_cur == V_START);
      locked       <= lock_nxt;
      timing_error <= err_nxt;
      if (valid_nxt) begin
        column <= hcnt_cur - H_START;
        row    <= 9'(vcnt_cur - V_START);
        pix_r  <= rgb_q.r;
        pix_g  <= rgb_q.g;
        pix_b  <= rgb_q.b;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken 15x9 raster (8x4 active)
// so whole frames, lock, error and re-lock sequences stay short.
module tb_vga_sync_decoder;
  localparam int HP = 8, HFP = 2, HPW = 3, HBP = 2;
  localparam int VP = 4, VFP = 1, VPW = 2, VBP = 2;
  localparam int HT = HP + HFP + HPW + HBP;
  localparam int VT = VP + VFP + VPW + VBP;
  localparam int HS = HPW + HBP;
  localparam int VS = VPW + VBP;

  logic       clk, rst, hs, vs;
  logic [7:0] r, g, b;
  logic [9:0] column;
  logic [8:0] row;
  logic [7:0] pix_r, pix_g, pix_b;
  logic       pixel_valid, frame_start, locked, timing_error;

  vga_sync_decoder #(
    .H_PIXELS(HP), .H_FP(HFP), .H_PULSE(HPW), .H_BP(HBP),
    .V_PIXELS(VP), .V_FP(VFP), .V_PULSE(VPW), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut (
    .pixel_clk(clk), .reset(rst), .h_sync(hs), .v_sync(vs),
    .red(r), .green(g), .blue(b),
    .column(column), .row(row), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
    .timing_error(timing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, vld_cnt, fs_cnt, fs_bad, pix_bad, err_cnt, err_cyc = -10, lock_cyc;
  bit err_lk, lk_after_err, lk_any;
  logic [9:0] cur_col, prv_col;
  logic [8:0] cur_row, prv_row;
  bit cur_act, prv_act;

  // Outputs sampled in a tick belong to the pixel driven in the previous tick.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (pixel_valid) begin
      vld_cnt++;
      if (!prv_act || column !== prv_col || row !== prv_row || pix_r !== column[7:0] ||
          pix_g !== row[7:0] || pix_b !== 8'hA5) pix_bad++;
    end
    if (frame_start) begin
      fs_cnt++;
      if (!pixel_valid || column !== 10'd0 || row !== 9'd0) fs_bad++;
    end
    if (timing_error) begin err_cnt++; err_cyc = cyc; err_lk = locked; end
    if (cyc == err_cyc + 1) lk_after_err = locked;
    if (locked) begin lk_any = 1'b1; if (lock_cyc < 0) lock_cyc = cyc; end
    prv_act = cur_act; prv_col = cur_col; prv_row = cur_row;
  endtask

  task automatic reset_stats();
    vld_cnt = 0; fs_cnt = 0; fs_bad = 0; pix_bad = 0; err_cnt = 0;
    lock_cyc = -1; lk_any = 1'b0; err_lk = 1'b1; lk_after_err = 1'b1;
  endtask

  task automatic drive_line(input int len, input int pw, input int y);
    for (int x = 0; x < len; x++) begin
      hs = (x < pw) ? 1'b0 : 1'b1;
      vs = (y < VPW) ? 1'b0 : 1'b1;
      cur_act = (x >= HS) && (x < HS + HP) && (y >= VS) && (y < VS + VP);
      cur_col = 10'(x - HS);
      cur_row = 9'(y - VS);
      if (cur_act) begin r = 8'(x - HS); g = 8'(y - VS); b = 8'hA5; end
      else begin r = 8'h3C; g = 8'h3C; b = 8'h3C; end
      tick();
    end
  endtask

  task automatic drive_lines(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) drive_line(HT, HPW, y);
  endtask

  task automatic idle(input int n);
    hs = 1'b1; vs = 1'b1; cur_act = 1'b0; r = '0; g = '0; b = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(2); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hs = 1'b0; vs = 1'b0; r = 8'hFF; g = 8'hFF; b = 8'hFF; cur_act = 1'b0;
    tick(); tick();
    tests++; if ({pixel_valid, frame_start, locked, timing_error} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000", {pixel_valid, frame_start, locked, timing_error}); end
    tests++; if (column !== 10'd0 || row !== 9'd0) begin
      fails++; $display("FAIL reset_pos: got col %0d row %0d expected 0 0", column, row); end
    tests++; if ({pix_r, pix_g, pix_b} !== 24'h0) begin
      fails++; $display("FAIL reset_pix: got %h expected 000000", {pix_r, pix_g, pix_b}); end
  endtask

  task automatic test_clean_stream();
    int f2;
    do_reset(); idle(4); reset_stats();
    drive_lines(0, VT - 1);
    tests++; if (lk_any || vld_cnt != 0) begin
      fails++; $display("FAIL measure_no_lock: got lock %0d valid %0d expected 0 0", lk_any, vld_cnt); end
    f2 = cyc; reset_stats();
    drive_lines(0, VT - 1);
    tests++; if (lock_cyc != f2 + 2) begin
      fails++; $display("FAIL lock_cycle: got %0d expected %0d", lock_cyc, f2 + 2); end
    tests++; if (vld_cnt != HP * VP || fs_cnt != 1) begin
      fails++; $display("FAIL frame2_counts: got valid %0d fs %0d expected %0d 1", vld_cnt, fs_cnt, HP * VP); end
    tests++; if (pix_bad != 0 || fs_bad != 0) begin
      fails++; $display("FAIL frame2_data: got bad pix %0d bad fs %0d expected 0 0", pix_bad, fs_bad); end
    reset_stats();
    drive_lines(0, VT - 1);
    tests++; if (vld_cnt != HP * VP || fs_cnt != 1 || pix_bad != 0 || fs_bad != 0) begin
      fails++; $display("FAIL frame3: got valid %0d fs %0d bad %0d/%0d", vld_cnt, fs_cnt, pix_bad, fs_bad); end
    tests++; if (err_cnt != 0 || locked !== 1'b1) begin
      fails++; $display("FAIL clean_locked: got err %0d locked %b expected 0 1", err_cnt, locked); end
  endtask

  task automatic test_long_line();
    int l6, f6;
    reset_stats();
    drive_lines(0, 4);
    drive_line(HT + 1, HPW, 5);
    l6 = cyc;
    drive_lines(6, VT - 1);
    tests++; if (err_cnt != 1 || err_cyc != l6 + 2) begin
      fails++; $display("FAIL long_err: got count %0d cyc %0d expected 1 %0d", err_cnt, err_cyc, l6 + 2); end
    tests++; if (err_lk || lk_after_err) begin
      fails++; $display("FAIL long_unlock: got locked %0d/%0d expected 0/0", err_lk, lk_after_err); end
    tests++; if (vld_cnt != 2 * HP) begin
      fails++; $display("FAIL long_valid: got %0d expected %0d", vld_cnt, 2 * HP); end
    reset_stats();
    drive_lines(0, VT - 1);
    tests++; if (lk_any || err_cnt != 0) begin
      fails++; $display("FAIL relock_measure: got lock %0d err %0d expected 0 0", lk_any, err_cnt); end
    f6 = cyc; reset_stats();
    drive_lines(0, VT - 1);
    tests++; if (lock_cyc != f6 + 2 || vld_cnt != HP * VP) begin
      fails++; $display("FAIL relock: got cyc %0d valid %0d expected %0d %0d", lock_cyc, vld_cnt, f6 + 2, HP * VP); end
  endtask

  task automatic test_short_pulse();
    int l1;
    do_reset(); idle(4); reset_stats();
    drive_line(HT, HPW, 0);
    l1 = cyc;
    drive_line(HT, HPW - 1, 1);
    drive_lines(2, VT - 1);
    tests++; if (err_cnt != 1 || err_cyc != l1 + 4) begin
      fails++; $display("FAIL short_err: got count %0d cyc %0d expected 1 %0d", err_cnt, err_cyc, l1 + 4); end
    drive_lines(0, VT - 1);
    tests++; if (lk_any || err_cnt != 1) begin
      fails++; $display("FAIL short_search: got lock %0d err %0d expected 0 1", lk_any, err_cnt); end
  endtask

  task automatic test_timeout();
    int t0;
    drive_lines(0, VT - 1);
    tests++; if (locked !== 1'b1) begin
      fails++; $display("FAIL timeout_pre: got locked %b expected 1", locked); end
    reset_stats();
    drive_lines(0, 2);
    t0 = cyc;
    idle(1100);
    tests++; if (err_cnt != 1 || err_cyc != t0 + 1010) begin
      fails++; $display("FAIL timeout_err: got count %0d cyc %0d expected 1 %0d", err_cnt, err_cyc, t0 + 1010); end
    tests++; if (locked !== 1'b0 || err_lk) begin
      fails++; $display("FAIL timeout_unlock: got locked %b/%0d expected 0/0", locked, err_lk); end
  endtask

  task automatic test_reset_midframe();
    int fi;
    do_reset(); idle(4);
    drive_lines(0, VT - 1);
    drive_lines(0, VT - 1);
    drive_lines(0, VS + 1);
    tests++; if (locked !== 1'b1 || column !== 10'(HP - 1) || row !== 9'd1) begin
      fails++; $display("FAIL midframe_pre: got locked %b col %0d row %0d expected 1 %0d 1", locked, column, row, HP - 1); end
    rst = 1'b1; hs = 1'b1; vs = 1'b1; cur_act = 1'b0;
    tick();
    rst = 1'b0;
    tests++; if ({pixel_valid, frame_start, locked, timing_error} !== 4'b0 ||
                 column !== 10'd0 || row !== 9'd0 || {pix_r, pix_g, pix_b} !== 24'h0) begin
      fails++; $display("FAIL midframe_rst: got flags %b col %0d row %0d pix %h expected all 0",
                        {pixel_valid, frame_start, locked, timing_error}, column, row, {pix_r, pix_g, pix_b}); end
    drive_lines(VS + 2, VT - 1);
    reset_stats();
    drive_lines(0, VT - 1);
    tests++; if (lk_any || err_cnt != 0) begin
      fails++; $display("FAIL midframe_measure: got lock %0d err %0d expected 0 0", lk_any, err_cnt); end
    fi = cyc; reset_stats();
    drive_lines(0, VT - 1);
    tests++; if (lock_cyc != fi + 2 || vld_cnt != HP * VP || fs_cnt != 1) begin
      fails++; $display("FAIL midframe_relock: got cyc %0d valid %0d fs %0d expected %0d %0d 1",
                        lock_cyc, vld_cnt, fs_cnt, fi + 2, HP * VP); end
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; r = '0; g = '0; b = '0;
    cur_act = 1'b0; cur_col = '0; cur_row = '0; prv_act = 1'b0; prv_col = '0; prv_row = '0;
    reset_stats();
    test_reset();
    test_clean_stream();
    test_long_line();
    test_short_pulse();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters: H_PIXELS 640, active columns; H_FP 16, horizontal front porch; H_PULSE 96, h_sync width; H_BP 48, horizontal back porch; V_PIXELS 480, active rows; V_FP 10; V_PULSE 2; V_BP 33; SYNC_POL 0, active sync level for both syncs.
REQ-002 SHALL have ports: pixel_clk  in  1  pixel clock, 25 MHz; one clock only.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 h_sync, v_sync  in  1 each  incoming VGA syncs.
REQ-005 red, green, blue  in  8 each  incoming pixel data.
REQ-006 column  out  10  recovered active column, 0..H_PIXELS-1.
REQ-007 row  out  9  recovered active row, 0..V_PIXELS-1.
REQ-008 pix_r, pix_g, pix_b  out  8 each  pixel data aligned with column/row.
REQ-009 pixel_valid  out  1  high when column/row/pix_* carry an active, locked pixel.
REQ-010 frame_start  out  1  one-cycle pulse with pixel (0,0).
REQ-011 locked  out  1  timing verified for a full frame.
REQ-012 timing_error  out  1  one-cycle pulse on any timing violation.

Function
REQ-013 All inputs SHALL be registered once; all outputs SHALL be registered, giving 2-cycle latency from input pins to column/row/pix_*/pixel_valid.
REQ-014 Sync assert edge SHALL mean the registered sync changes to SYNC_POL; deassert edge SHALL mean it leaves SYNC_POL.
REQ-015 hcount (10 bits) SHALL load 0 on h_sync assert edge, otherwise increment, saturating at 1023.
REQ-016 vcount (10 bits) SHALL load 0 on v_sync assert edge, increment on each h_sync assert edge otherwise, and saturate at 1023; on simultaneous edges, load 0 takes priority.
REQ-017 Active window: hcount in [H_PULSE+H_BP, H_PULSE+H_BP+H_PIXELS-1] and vcount in [V_PULSE+V_BP, V_PULSE+V_BP+V_PIXELS-1]; column = hcount-(H_PULSE+H_BP), row = vcount-(V_PULSE+V_BP).
REQ-018 pixel_valid SHALL be high only when locked and in the active window; column/row/pix_* SHALL hold last values when pixel_valid is low.
REQ-019 frame_start SHALL pulse in the same cycle pixel_valid is high with column 0, row 0.
REQ-020 Checks, with H_TOTAL = 800 and V_TOTAL = 525 derived from the parameters: h_sync assert-to-deassert = H_PULSE cycles; h_sync assert-to-assert = H_TOTAL cycles; v_sync assert-to-deassert = V_PULSE lines; v_sync assert-to-assert = V_TOTAL lines.
REQ-021 Timeout SHALL be flagged as a violation when hcount saturates at 1023 (no h_sync edge).
REQ-022 FSM states SHALL be SEARCH, MEASURE, LOCKED.
REQ-023 SEARCH: locked=0; first v_sync assert edge goes to MEASURE; violations are ignored.
REQ-024 MEASURE: locked=0; any violation goes to SEARCH and pulses timing_error; next v_sync assert edge with zero violations goes to LOCKED.
REQ-025 LOCKED: locked=1; any violation goes to SEARCH, pulses timing_error, and drops locked and pixel_valid in the next cycle.
REQ-026 Mid-line violations SHALL not corrupt counters; counters always track edges per REQ-015/016.

Reset
REQ-027 In the reset cycle, the FSM SHALL go to SEARCH, and hcount, vcount, column, row, pix_* SHALL be 0.
REQ-028 In the reset cycle, pixel_valid, frame_start, locked and timing_error SHALL be 0.
REQ-029 Registered syncs SHALL reset to the inactive level (~SYNC_POL), so an input already at SYNC_POL after reset counts as an assert edge.
REQ-030 Reset mid-frame SHALL abort lock; re-lock requires one full clean frame after the next v_sync assert edge.

Verification
REQ-031 Clean 640x480 stream, 3 frames, RGB = {column[7:0], row[7:0], 8'hA5} -> locked rises at second v_sync assert edge; 307200 valid pixels per locked frame; pix_* match column/row.
REQ-032 Locked stream, one line with 801 cycles -> timing_error pulses once, locked=0 next cycle, re-lock after 2 clean v_sync edges.
REQ-033 h_sync pulse of 95 cycles during MEASURE -> timing_error pulse, state SEARCH, locked stays 0.
REQ-034 h_sync held inactive for 1100 cycles while locked -> timing_error at hcount=1023, locked=0.
REQ-035 Reset asserted at row 200 of a locked frame -> all outputs 0 next cycle; locked=1 only after a further full clean frame.
REQ-036 Locked stream -> frame_start exactly one pulse per frame, coincident with column=0, row=0, pixel_valid=1; latency from input pixel to output = 2 cycles.
